// File: rtl/comb_controller_pkg.sv
// Shared definitions for the recursive-combination controller.
//   state_e : FSM state encoding (4 bits, IDLE..NEXT)
//   SEL_*   : n/m stack input mux selects (decrement, stack out, operand)
//   SLD_*   : decrementer source select (n-stack out / m-stack out)
//   ctrl_t  : bundle of the Moore-decoded datapath strobes
package comb_controller_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CLEAR  = 4'd1,
    LOAD   = 4'd2,
    POP    = 4'd3,
    CHECK  = 4'd4,
    PUSH_A = 4'd5,
    PUSH_T = 4'd6,
    POP_T  = 4'd7,
    PUSH_B = 4'd8,
    NEXT   = 4'd9
  } state_e;

  localparam logic [1:0] SEL_DEC = 2'b00;
  localparam logic [1:0] SEL_STK = 2'b01;
  localparam logic [1:0] SEL_IN  = 2'b10;

  localparam logic SLD_N = 1'b1;
  localparam logic SLD_M = 1'b0;

  typedef struct packed {
    logic [1:0] sl1;
    logic [1:0] sl2;
    logic       sld;
    logic       push;
    logic       pop;
    logic       dp_rst;
    logic       busy;
  } ctrl_t;

  // State-only part of the output decode; the CHECK-dependent enable is
  // handled alongside the next-state logic.
  function automatic ctrl_t decode(input state_e s);
    ctrl_t c;
    c        = '0;
    c.sl1    = SEL_DEC;
    c.sl2    = SEL_DEC;
    c.sld    = SLD_M;
    c.busy   = (s != IDLE);
    case (s)
      CLEAR: c.dp_rst = 1'b1;
      LOAD: begin
        c.push = 1'b1;
        c.sl1  = SEL_IN;
        c.sl2  = SEL_IN;
      end
      POP, POP_T: c.pop = 1'b1;
      PUSH_A, PUSH_B: begin
        c.push = 1'b1;
        c.sl1  = SEL_DEC;
        c.sld  = SLD_N;
        c.sl2  = SEL_STK;
      end
      PUSH_T: begin
        c.push = 1'b1;
        c.sl1  = SEL_STK;
        c.sl2  = SEL_DEC;
        c.sld  = SLD_M;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/comb_controller.sv
// Control FSM for the recursive-combination datapath computing C(n,m) by
// depth-first expansion C(n,m) = C(n-1,m) + C(n-1,m-1), leaves counting 1.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, n, m       : run request and operands (sampled in IDLE)
//   end_point, empty  : datapath flags (leaf at top / stack empty)
//   sl1, sl2, sld     : stack input mux selects and decrement source
//   push, pop, top    : stack strobes (top tied low)
//   enable            : leaf counter increment
//   dp_rst            : one-cycle datapath clear
//   busy, done, err   : run status
module comb_controller
  import comb_controller_pkg::*;
#(
  parameter int unsigned NM_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NM_W-1:0] n,
  input  logic [NM_W-1:0] m,
  input  logic            end_point,
  input  logic            empty,
  output logic [1:0]      sl1,
  output logic [1:0]      sl2,
  output logic            sld,
  output logic            push,
  output logic            pop,
  output logic            top,
  output logic            enable,
  output logic            dp_rst,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_e state_q, state_d;
  logic   done_q, done_d;
  logic   err_q, err_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    err_d   = err_q;
    enable  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (m > n) begin
            // Rejected run: report through done/err without leaving IDLE.
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            done_d  = 1'b0;
            state_d = CLEAR;
          end
        end
      end
      CLEAR:  state_d = LOAD;
      LOAD:   state_d = POP;
      POP:    state_d = CHECK;
      CHECK: begin
        if (end_point) begin
          enable  = 1'b1;
          state_d = NEXT;
        end else begin
          state_d = PUSH_A;
        end
      end
      PUSH_A: state_d = PUSH_T;
      PUSH_T: state_d = POP_T;
      POP_T:  state_d = PUSH_B;
      PUSH_B: state_d = NEXT;
      NEXT: begin
        if (empty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = POP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ctrl   = decode(state_q);
  assign sl1    = ctrl.sl1;
  assign sl2    = ctrl.sl2;
  assign sld    = ctrl.sld;
  assign push   = ctrl.push;
  assign pop    = ctrl.pop;
  assign dp_rst = ctrl.dp_rst;
  assign busy   = ctrl.busy;
  assign top    = 1'b0;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_comb_controller.sv
module tb_comb_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] n_in = '0;
  logic [3:0] m_in = '0;
  logic       end_point, empty;
  logic [1:0] sl1, sl2;
  logic       sld, push, pop, top, enable, dp_rst, busy, done, err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  comb_controller #(.NM_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n_in), .m(m_in),
    .end_point(end_point), .empty(empty),
    .sl1(sl1), .sl2(sl2), .sld(sld), .push(push), .pop(pop), .top(top),
    .enable(enable), .dp_rst(dp_rst), .busy(busy), .done(done), .err(err)
  );

  // Behavioural datapath: paired n/m stacks, pop-loaded output registers,
  // shared decrementer, 13-bit leaf counter.
  logic [3:0]  nstk [32];
  logic [3:0]  mstk [32];
  logic [5:0]  sp = '0;
  logic [3:0]  nout = '0, mout = '0;
  logic [12:0] cnt = '0;
  logic [3:0]  dec, nin, min;

  assign dec = (sld ? nout : mout) - 4'd1;
  assign nin = (sl1 == 2'b00) ? dec : (sl1 == 2'b01) ? nout : n_in;
  assign min = (sl2 == 2'b00) ? dec : (sl2 == 2'b01) ? mout : m_in;
  assign end_point = (mout == 4'd0) || (nout == mout);
  assign empty = (sp == 6'd0);

  always @(posedge clk) begin
    if (rst || dp_rst) begin
      sp <= '0; cnt <= '0; nout <= '0; mout <= '0;
    end else begin
      if (push) begin
        nstk[sp[4:0]] <= nin;
        mstk[sp[4:0]] <= min;
        sp <= sp + 6'd1;
      end else if (pop) begin
        nout <= nstk[sp[4:0] - 5'd1];
        mout <= mstk[sp[4:0] - 5'd1];
        sp <= sp - 6'd1;
      end
      if (enable) cnt <= cnt + 13'd1;
    end
  end

  // Activity monitor, cleared by the bench at the start of each run.
  logic clr_mon = 1'b0;
  int dprst_cnt = 0, push_cnt = 0, busy_cnt = 0, top_cnt = 0, maxsp = 0;
  always @(posedge clk) begin
    if (clr_mon) begin
      dprst_cnt <= 0; push_cnt <= 0; busy_cnt <= 0; top_cnt <= 0; maxsp <= 0;
    end else begin
      if (dp_rst) dprst_cnt <= dprst_cnt + 1;
      if (push)   push_cnt  <= push_cnt + 1;
      if (busy)   busy_cnt  <= busy_cnt + 1;
      if (top)    top_cnt   <= top_cnt + 1;
      if (int'(sp) > maxsp) maxsp <= int'(sp);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},   int'(busy),   0);
    check({tag, "_done"},   int'(done),   0);
    check({tag, "_err"},    int'(err),    0);
    check({tag, "_strobe"}, int'({push, pop, top, enable, dp_rst}), 0);
    check({tag, "_sel"},    int'({sl1, sl2, sld}), 0);
  endtask

  // Start a run and wait for busy to fall; glitch >= 0 pulses start with
  // n=2, m=1 at that busy cycle.
  task automatic run_ok(input logic [3:0] nv, input logic [3:0] mv,
                        input int exp_cnt, input int exp_cyc,
                        input int glitch, input string tag);
    int cyc;
    @(negedge clk);
    n_in = nv; m_in = mv; start = 1'b1; clr_mon = 1'b1;
    @(negedge clk);
    start = 1'b0; clr_mon = 1'b0;
    check({tag, "_clear_done"}, int'(done), 0);
    check({tag, "_clear_err"},  int'(err),  0);
    cyc = 0;
    while (busy && cyc < 70000) begin
      cyc++;
      if (cyc == glitch) begin
        start = 1'b1; n_in = 4'd2; m_in = 4'd1;
      end else begin
        start = 1'b0; n_in = nv; m_in = mv;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_cycles"}, cyc, exp_cyc);
    check({tag, "_done"},   int'(done), 1);
    check({tag, "_err"},    int'(err),  0);
    check({tag, "_count"},  int'(cnt),  exp_cnt);
    check({tag, "_dp_rst"}, dprst_cnt,  1);
    check({tag, "_top"},    top_cnt,    0);
    check({tag, "_depth"},  int'(maxsp <= int'(nv) + 1), 1);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("post_reset");

    run_ok(4'd4, 4'd2, 6, 55, -1, "n4m2");
    run_ok(4'd5, 4'd0, 1, 5, -1, "n5m0");
    run_ok(4'd0, 4'd0, 1, 5, -1, "n0m0");

    // m > n is rejected in IDLE.
    @(negedge clk);
    n_in = 4'd3; m_in = 4'd5; start = 1'b1; clr_mon = 1'b1;
    @(negedge clk);
    start = 1'b0; clr_mon = 1'b0;
    check("rej_err",  int'(err),  1);
    check("rej_done", int'(done), 1);
    check("rej_busy", int'(busy), 0);
    repeat (4) @(negedge clk);
    check("rej_push",    push_cnt,  0);
    check("rej_dp_rst",  dprst_cnt, 0);
    check("rej_busy_cnt", busy_cnt, 0);

    run_ok(4'd15, 4'd7, 6435, 64345, -1, "n15m7");

    // Reset in the middle of a run.
    @(negedge clk);
    n_in = 4'd6; m_in = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (k < 20) begin
      k++;
      @(negedge clk);
    end
    check("mid_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_zero("mid_rst");
    rst = 1'b0;
    run_ok(4'd6, 4'd3, 20, 195, -1, "n6m3");

    // start pulsed mid-run is ignored.
    run_ok(4'd4, 4'd2, 6, 55, 10, "glitch");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
